// File: rtl/dm_store_buffer.sv
// dm_store_buffer
// Word-store FIFO between the MEM-stage store path and the data memory write port.
// Stores are held in program order and retired one per cycle when the DM port is free.
// Buffered stores forward their data to loads that hit the same word address.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   st_valid/st_ready     store handshake; st_addr/st_data/st_pc are the store payload
//   ld_addr               load address checked against buffered stores
//   ld_hit/ld_data        youngest matching buffered store (data 0 on miss)
//   drain_en              DM write port available this cycle
//   dm_addr/dm_wd/dm_we/dm_pc  DM write port, driven from the head entry
//   count/empty           occupancy
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [31:0]      st_pc,
    output logic             st_ready,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    input  logic             drain_en,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wd,
    output logic             dm_we,
    output logic [31:0]      dm_pc,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic push, pop;
    logic unused_addr_lsbs;

    // Only word stores/loads exist, so the byte offset bits carry no information.
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    // Ready depends only on registered occupancy; a same-cycle pop does not free a slot.
    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push     = st_valid && st_ready;
    assign dm_we    = !empty && drain_en;
    assign pop      = dm_we;

    assign dm_addr = empty ? 32'h0 : {addr_q[head_q], 2'b00};
    assign dm_wd   = empty ? 32'h0 : data_q[head_q];
    assign dm_pc   = empty ? 32'h0 : pc_q[head_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        // Push and pop never target the same slot: that would need count 0 (no pop)
        // or count DEPTH (no push).
        if (push) begin
            valid_d[tail_q] = 1'b1;
        end
    end

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        ld_hit  = 1'b0;
        ld_data = 32'h0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && valid_q[idx] && (addr_q[idx] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
        end
    end

    // Payload needs no reset: it is only observed through valid, counted entries.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr[31:2];
            data_q[tail_q] <= st_data;
            pc_q[tail_q]   <= st_pc;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr, st_data, st_pc;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        drain_en;
    logic [31:0] dm_addr, dm_wd, dm_pc;
    logic        dm_we;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_pc    (st_pc),
        .st_ready (st_ready),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .drain_en (drain_en),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_we    (dm_we),
        .dm_pc    (dm_pc),
        .count    (count),
        .empty    (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] p);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_pc    = p;
    endtask

    initial begin
        reset    = 1'b1;
        drain_en = 1'b0;
        ld_addr  = 32'h0;
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_we", 32'(dm_we), 32'd0);
        check("rst_hit", 32'(ld_hit), 32'd0);
        check("rst_dm_addr", dm_addr, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Single store, drained the cycle after push.
        drain_en = 1'b1;
        set_store(1'b1, 32'h28, 32'hFFFF_FFFF, 32'h318);
        #1;
        check("t1_not_yet_we", 32'(dm_we), 32'd0);
        tick();
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("t1_we", 32'(dm_we), 32'd1);
        check("t1_addr", dm_addr, 32'h28);
        check("t1_wd", dm_wd, 32'hFFFF_FFFF);
        check("t1_pc", dm_pc, 32'h318);
        check("t1_count1", 32'(count), 32'd1);
        tick();
        #1;
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_count0", 32'(count), 32'd0);
        check("t1_we_off", 32'(dm_we), 32'd0);
        check("t1_addr_zero", dm_addr, 32'h0);

        // Fill under stall, refuse fifth push, then drain in order.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 32'h1000 + 32'(i));
            tick();
        end
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("t2_count_full", 32'(count), 32'd4);
        check("t2_ready_low", 32'(st_ready), 32'd0);
        set_store(1'b1, 32'h10, 32'hDEAD, 32'h2000);
        tick();
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("t2_fifth_refused", 32'(count), 32'd4);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_drain_we", 32'(dm_we), 32'd1);
            check("t2_drain_addr", dm_addr, 32'(4 * i));
            check("t2_drain_wd", dm_wd, 32'hA0 + 32'(i));
            check("t2_drain_pc", dm_pc, 32'h1000 + 32'(i));
            tick();
            if (i == 0) begin
                check("t2_ready_after_pop", 32'(st_ready), 32'd1);
            end
        end
        #1;
        check("t2_empty", 32'(empty), 32'd1);

        // Forwarding: youngest match wins; push not visible in its own cycle.
        drain_en = 1'b0;
        ld_addr  = 32'h42;
        set_store(1'b1, 32'h40, 32'h1111_1111, 32'h3000);
        #1;
        check("t3_push_invisible", 32'(ld_hit), 32'd0);
        tick();
        set_store(1'b1, 32'h40, 32'h2222_2222, 32'h3004);
        #1;
        check("t3_first_fwd", ld_data, 32'h1111_1111);
        tick();
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("t3_hit", 32'(ld_hit), 32'd1);
        check("t3_youngest", ld_data, 32'h2222_2222);
        ld_addr = 32'h44;
        #1;
        check("t3_miss_hit", 32'(ld_hit), 32'd0);
        check("t3_miss_data", ld_data, 32'h0);
        ld_addr  = 32'h40;
        drain_en = 1'b1;
        tick();
        #1;
        // Remaining entry is the head being drained this cycle; still forwards.
        check("t3_head_drain_hit", 32'(ld_hit), 32'd1);
        check("t3_head_drain_data", ld_data, 32'h2222_2222);
        check("t3_head_wd", dm_wd, 32'h2222_2222);
        tick();
        #1;
        check("t3_drained_miss", 32'(ld_hit), 32'd0);
        ld_addr = 32'h0;

        // Concurrent push and pop for 10 cycles; pointers start at 3 so both wrap.
        for (int i = 0; i < 10; i++) begin
            set_store(1'b1, 32'h100 + 32'(4 * i), 32'h5000 + 32'(i), 32'h6000 + 32'(i));
            #1;
            if (i > 0) begin
                check("t4_count", 32'(count), 32'd1);
                check("t4_we", 32'(dm_we), 32'd1);
                check("t4_addr", dm_addr, 32'h100 + 32'(4 * (i - 1)));
                check("t4_wd", dm_wd, 32'h5000 + 32'(i - 1));
            end
            tick();
        end
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("t4_last_addr", dm_addr, 32'h124);
        check("t4_last_pc", dm_pc, 32'h6009);
        tick();
        #1;
        check("t4_empty", 32'(empty), 32'd1);

        // Reset between edges with 3 entries buffered and a drain in progress.
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, 32'h200 + 32'(4 * i), 32'h7000 + 32'(i), 32'h8000);
            tick();
        end
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        drain_en = 1'b1;
        ld_addr  = 32'h200;
        #1;
        check("t5_pre_we", 32'(dm_we), 32'd1);
        check("t5_pre_count", 32'(count), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_we", 32'(dm_we), 32'd0);
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_ready", 32'(st_ready), 32'd1);
        check("t5_rst_hit", 32'(ld_hit), 32'd0);
        check("t5_rst_data", ld_data, 32'h0);
        check("t5_rst_dm_wd", dm_wd, 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_no_stale_we", 32'(dm_we), 32'd0);
            tick();
        end
        set_store(1'b1, 32'h300, 32'h9999, 32'h9000);
        tick();
        set_store(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("t5_post_addr", dm_addr, 32'h300);
        check("t5_post_wd", dm_wd, 32'h9999);
        tick();
        #1;
        check("t5_post_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Word-store buffer between the MEM-stage store path and the data memory (DM). It accepts store requests from the pipeline, holds up to DEPTH of them in FIFO order, and retires one per cycle into the DM write port (address, write data, MemWrite, PC). Buffered stores remain visible to loads through an address-match forwarding path, so loads issued after a buffered store read that store's data rather than stale DM contents.

## Interface
- DEPTH, 4, number of buffered stores; power of two, 2..16
- PTR_W, log2(DEPTH), FIFO pointer width

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears the buffer
- st_valid  in  1  store request from MEM stage
- st_addr  in  32  store byte address; bits [1:0] ignored (word stores only)
- st_data  in  32  store data
- st_pc  in  32  PC of the store instruction, carried to DM for its write log
- st_ready  out  1  buffer can accept a store this cycle
- ld_addr  in  32  MEM-stage load address for the forwarding check; bits [1:0] ignored
- ld_hit  out  1  ld_addr matches a buffered store
- ld_data  out  32  data of the youngest matching entry; 0 when ld_hit=0
- drain_en  in  1  DM write port available this cycle
- dm_addr  out  32  to DM address input: {head word address, 2'b00}
- dm_wd  out  32  to DM WD
- dm_we  out  1  to DM MemWrite
- dm_pc  out  32  to DM PC
- count  out  PTR_W+1  number of valid entries
- empty  out  1  count == 0

## Operation
- Storage: DEPTH entries of {word address [31:2], data, pc, valid}. head_ptr and tail_ptr are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits.
- Push: on the rising edge with st_valid && st_ready, write the entry at tail, set it valid, and increment tail.
- st_ready = (count != DEPTH). It depends only on the registered count and not on a same-cycle pop, so a push into a full buffer is always refused, even in a cycle where a pop occurs.
- st_valid while st_ready=0 is ignored. The store is not captured, and holding st_valid high until st_ready returns is the requester's responsibility.
- Drain: dm_we = !empty && drain_en. dm_addr, dm_wd and dm_pc are driven combinationally from the head entry, and are 0 when empty. On an edge where dm_we=1, DM commits the write and the buffer invalidates the head entry and increments head.
- Simultaneous push and pop: both take effect and count is unchanged. A push to an empty buffer does not drain in the same cycle (dm_we reflects the registered state).
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Forwarding: combinational compare of ld_addr[31:2] against every valid entry. When several entries match, the youngest (closest to tail) wins. The head entry being drained in the current cycle still matches, because DM is not updated until that edge. A store being pushed in the current cycle is not visible until the next cycle.
- Duplicate addresses are kept as separate entries. There is no coalescing, and DM receives every store in program order.
- Reset, asynchronous and valid at any time including mid-drain:
  - Pointers 0, count 0, all valid bits 0; entries are discarded.
  - st_ready=1, empty=1, dm_we=0, ld_hit=0, ld_data=0, and dm_addr, dm_wd, dm_pc all 0.
  - Entry payload registers need not be cleared.

## Timing
- Push to drain-eligible: 1 cycle. A store pushed at edge N appears on the dm_* outputs after edge N and is written at edge N+1 if drain_en=1.
- Throughput: 1 push and 1 pop per cycle.
- Push to forwarding visible: 1 cycle.
- Drain stall: when drain_en=0 the head holds and count can only grow. At count==DEPTH, st_ready drops in the cycle after the filling edge.
- Wrap-around: tail or head moving from DEPTH−1 to 0 is seamless, with no bubble.
- All outputs except registered state are combinational from registers, ld_addr and drain_en. There is no combinational path from st_valid, st_addr or st_data to any output.

## Test plan
- Reset then a single store. Push st_addr=0x28, st_data=0xFFFFFFFF, st_pc=0x318 with drain_en=1. Required: the next cycle shows dm_we=1, dm_addr=0x28, dm_wd=0xFFFFFFFF, dm_pc=0x318; the following cycle empty=1 and count=0.
- Fill under stall. With drain_en=0, push to 0x0, 0x4, 0x8, 0xC. Required: count=4, st_ready=0. A fifth push of 0x10 is refused. After raising drain_en, DM sees 0x0, 0x4, 0x8, 0xC in order over 4 cycles and st_ready=1 after the first pop.
- Forwarding youngest-wins. With drain_en=0, push 0x40←0x11111111 then 0x40←0x22222222, with ld_addr=0x42. Required: ld_hit=1, ld_data=0x22222222. With ld_addr=0x44, required ld_hit=0, ld_data=0.
- Concurrent push and pop with wrap. With DEPTH=4 and drain_en=1, push on 10 consecutive cycles. Required: count holds at 1 from the second cycle, DM receives all 10 stores in order, and the pointers wrap without loss.
- Reset mid-operation. With 3 entries buffered and dm_we=1, assert reset between clock edges. Required: dm_we=0, count=0, st_ready=1, ld_hit=0 immediately. After release, no stale store reaches DM.
